fir3_inverse_deconv: RTL and testbench
======================================

// Module: fir3_inverse_deconv
// PURPOSE
//  Inverse (deconvolution) stage for the 3-tap FIR: recovers x[n] from y[n] = A*x[n-2] + B*x[n-1] + C*x[n].
//  Uses a residual subtract followed by a multi-cycle restoring divide by C, with valid/ready on both sides.
//  Sits at the receive end of a filtered sample stream and keeps its own 2-deep history of recovered samples.
// PARAMETERS
//  DW  8   recovered sample width (unsigned)
//  YW  12  filtered input sample width (unsigned)
//  CW  4   coefficient width (unsigned)
//  A   1   coefficient on x[n-2]
//  B   2   coefficient on x[n-1]
//  C   3   coefficient on x[n]; must be nonzero (C=0 is a configuration error, no behaviour defined)
// PORTS
//  clk        in   1   single clock, all logic on posedge
//  rst        in   1   synchronous, active-high reset
//  y_in       in   YW  filtered sample
//  in_valid   in   1   y_in valid
//  in_ready   out  1   block can accept y_in
//  flush      in   1   clear history (x1,x2) to 0
//  x_out      out  DW  recovered sample
//  err        out  1   x_out not exact (negative, remainder, or clipped); qualified by out_valid
//  out_valid  out  1   x_out/err valid
//  out_ready  in   1   downstream accepts x_out
// BEHAVIOUR
//  Reset (sync): state=IDLE, x1=x2=0, x_out=0, err=0, out_valid=0, in_ready=1, divider regs=0.
//  Reset mid-operation: any in-flight sample is discarded; no out_valid is produced for it.
//  FSM: IDLE -> SUB -> DIV -> DONE -> IDLE.
//   IDLE: in_ready=1. Transfer on in_valid&in_ready: latch y_in, go SUB.
//     flush in IDLE clears x1,x2; flush together with in_valid: flush wins, in_ready=0 that cycle, no transfer.
//     flush in any other state is ignored.
//   SUB (1 cycle): r = y - B*x1 - A*x2 in signed width YW+2*CW+DW+2 (no overflow possible).
//     r<0: set neg flag, load dividend 0. Else load dividend r[YW-1:0] (r<=y, fits YW bits).
//   DIV (exactly YW cycles): restoring divide, one quotient bit per cycle, MSB first, divisor C.
//   DONE: x_out/err registered on entry, out_valid=1, held stable until out_ready; on out_valid&out_ready -> IDLE.
//  Result rules (applied on DONE entry, first matching rule wins):
//   neg            -> x_out=0,         err=1
//   q > 2^DW-1     -> x_out=2^DW-1,    err=1
//   remainder != 0 -> x_out=q[DW-1:0], err=1
//   otherwise      -> x_out=q[DW-1:0], err=0
//  History: on DONE entry x2<=x1, x1<=x_out (the clipped value that was emitted).
//  in_ready=0 in SUB/DIV/DONE: one sample in flight, no pipelining.
//  Latency: accept in cycle T -> out_valid first high in cycle T+YW+2.
//   YW=12: T+14. Minimum sample period YW+3 cycles with out_ready held high.
//  out_valid deasserts the cycle after acceptance; err/x_out keep last value while out_valid=0.
// TESTING (defaults A=1,B=2,C=3,DW=8,YW=12)
//  1 Exact recovery: from reset send y=15,31,46 -> x_out=5,7,9, err=0 each; out_valid 14 cycles after each accept.
//  2 Remainder: from reset send y=16 -> x_out=5, err=1; then y=31 -> r=21, x_out=7, err=0.
//  3 Negative residual: after x=5 recovered (test 1 first sample), send y=4 -> r=-6, x_out=0, err=1.
//    Then x1=0, x2=5.
//  4 Clip: from reset send y=1000 -> q=333 -> x_out=255, err=1; next y=0 -> r=-510, x_out=0, err=1.
//  5 Backpressure/flush: hold out_ready=0 for 5 cycles in DONE -> out_valid, x_out, err stable, in_ready=0.
//    Then flush+in_valid in IDLE -> no transfer, history=0; next y=15 -> x_out=5.
//  6 Reset mid-DIV: assert rst 6 cycles after accepting y=46 -> out_valid never rises, in_ready=1 next cycle.
//    Then y=15 -> x_out=5, err=0.

Source files
------------

// File: rtl/fir3_inverse_deconv.sv
// Inverse stage of the 3-tap FIR: subtracts the contribution of the two previous recovered
// samples, then divides the residual by C with a bit-serial restoring divider.
module fir3_inverse_deconv #(
    parameter int DW = 8,
    parameter int YW = 12,
    parameter int CW = 4,
    parameter int A  = 1,
    parameter int B  = 2,
    parameter int C  = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [YW-1:0] y_in,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          flush,
    output logic [DW-1:0] x_out,
    output logic          err,
    output logic          out_valid,
    input  logic          out_ready
);

    localparam int RW = YW + 2*CW + DW + 2;
    localparam int NW = $clog2(YW);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SUB  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam logic [CW:0]   DIVISOR  = (CW+1)'(C);
    localparam logic [NW-1:0] LAST_CNT = NW'(YW-1);

    logic [1:0]    state_reg;
    logic [YW-1:0] y_reg;
    logic [YW-1:0] dvd_reg;
    logic [YW-1:0] dvd_next;
    logic [CW-1:0] rem_reg;
    logic [CW-1:0] rem_next;
    logic [NW-1:0] cnt_reg;
    logic          neg_reg;
    logic [DW-1:0] x1_reg;
    logic [DW-1:0] x2_reg;
    logic [DW-1:0] x_out_reg;
    logic          err_reg;

    logic [RW-1:0] resid;
    logic          resid_neg;
    logic [CW:0]   trial;
    logic          trial_ge;
    logic          q_over;
    logic          err_res;
    logic [DW-1:0] x_res;

    assign in_ready  = (state_reg == S_IDLE) && !flush;
    assign out_valid = (state_reg == S_DONE);
    assign x_out     = x_out_reg;
    assign err       = err_reg;

    always_comb begin
        resid     = RW'(y_reg) - RW'(B) * RW'(x1_reg) - RW'(A) * RW'(x2_reg);
        resid_neg = $signed(resid) < 0;
    end

    // One restoring-divide step: the dividend register shifts out its MSB and shifts in the quotient bit.
    always_comb begin
        trial    = {rem_reg, dvd_reg[YW-1]};
        trial_ge = (trial >= DIVISOR);
        rem_next = trial_ge ? CW'(trial - DIVISOR) : trial[CW-1:0];
        dvd_next = {dvd_reg[YW-2:0], trial_ge};
    end

    // Result formed from the final step's quotient/remainder so it registers on DONE entry.
    assign q_over  = |dvd_next[YW-1:DW];
    assign err_res = neg_reg | q_over | (rem_next != '0);

    genvar gi;
    generate
        for (gi = 0; gi < DW; gi++) begin : g_sat
            assign x_res[gi] = !neg_reg && (q_over || dvd_next[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            y_reg     <= '0;
            dvd_reg   <= '0;
            rem_reg   <= '0;
            cnt_reg   <= '0;
            neg_reg   <= 1'b0;
            x1_reg    <= '0;
            x2_reg    <= '0;
            x_out_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (flush) begin
                        x1_reg <= '0;
                        x2_reg <= '0;
                    end else if (in_valid) begin
                        y_reg     <= y_in;
                        state_reg <= S_SUB;
                    end
                end
                S_SUB: begin
                    neg_reg   <= resid_neg;
                    dvd_reg   <= resid_neg ? '0 : resid[YW-1:0];
                    rem_reg   <= '0;
                    cnt_reg   <= '0;
                    state_reg <= S_DIV;
                end
                S_DIV: begin
                    dvd_reg <= dvd_next;
                    rem_reg <= rem_next;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_CNT) begin
                        x_out_reg <= x_res;
                        err_reg   <= err_res;
                        x2_reg    <= x1_reg;
                        x1_reg    <= x_res;
                        state_reg <= S_DONE;
                    end
                end
                default: begin
                    if (out_ready) begin
                        state_reg <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir3_inverse_deconv.sv
// Bench for fir3_inverse_deconv: directed scenarios plus random samples against an arithmetic model.
module tb_fir3_inverse_deconv;

    localparam int A = 1;
    localparam int B = 2;
    localparam int C = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] y_in = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic [7:0]  x_out;
    logic        err;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int n_checks = 0;
    int n_pass = 0;
    int m_x1 = 0;
    int m_x2 = 0;

    always #5 clk = ~clk;

    fir3_inverse_deconv #(.DW(8), .YW(12), .CW(4), .A(A), .B(B), .C(C)) dut (
        .clk(clk), .rst(rst), .y_in(y_in), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .x_out(x_out), .err(err), .out_valid(out_valid), .out_ready(out_ready)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference: exact arithmetic with integer division, then the saturation/error rules.
    task automatic model(input int y, output int x, output int e);
        int r;
        int q;
        r = y - B * m_x1 - A * m_x2;
        if (r < 0) begin
            x = 0; e = 1;
        end else begin
            q = r / C;
            if (q > 255) begin
                x = 255; e = 1;
            end else begin
                x = q; e = (r % C != 0) ? 1 : 0;
            end
        end
        m_x2 = m_x1;
        m_x1 = x;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_x1 = 0; m_x2 = 0;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_x_out", int'(x_out), 0);
        check("rst_err", int'(err), 0);
    endtask

    task automatic send(input int y, input int hold);
        int x_e, e_e, lat, w;
        @(negedge clk);
        y_in = 12'(y); in_valid = 1'b1; w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk); w++;
        end
        check("accept_wait", int'(w < 50), 1);
        @(negedge clk);
        in_valid = 1'b0; lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk); lat++;
        end
        check("latency", lat, 14);
        model(y, x_e, e_e);
        check("x_out", int'(x_out), x_e);
        check("err", int'(err), e_e);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", int'(out_valid), 1);
            check("hold_in_ready", int'(in_ready), 0);
            check("hold_x_out", int'(x_out), x_e);
            check("hold_err", int'(err), e_e);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("valid_drop", int'(out_valid), 0);
        check("idle_ready", int'(in_ready), 1);
        $display("y=%0d x_out=%0d err=%0d exp_x=%0d exp_err=%0d lat=%0d hold=%0d",
                 y, x_out, err, x_e, e_e, lat, hold);
    endtask

    initial begin
        int y, hits, x0, x1v, x2v;

        do_reset();
        // exact recovery
        send(15, 0); send(31, 0); send(46, 0);
        // remainder
        do_reset();
        send(16, 0); send(31, 0);
        // negative residual after x=5
        do_reset();
        send(15, 0); send(4, 0); send(20, 0);
        // clip then negative
        do_reset();
        send(1000, 0); send(0, 0);

        // backpressure, then flush colliding with in_valid
        do_reset();
        send(15, 5);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; y_in = 12'd99;
        #1 check("flush_in_ready", int'(in_ready), 0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        m_x1 = 0; m_x2 = 0;
        repeat (3) begin
            @(negedge clk);
            check("flush_no_xfer", int'(out_valid), 0);
        end
        $display("flush+in_valid: in_ready=%0d out_valid=%0d", in_ready, out_valid);
        send(15, 0);

        // reset during the divide
        do_reset();
        @(negedge clk);
        y_in = 12'd46; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_x1 = 0; m_x2 = 0;
        check("midrst_in_ready", int'(in_ready), 1);
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) hits++;
        end
        check("midrst_no_valid", hits, 0);
        $display("reset mid-divide: stray out_valid cycles=%0d", hits);
        send(15, 0);

        // random traffic: mostly consistent streams, some arbitrary samples and flushes
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                @(negedge clk); flush = 1'b1;
                @(negedge clk); flush = 1'b0;
                m_x1 = 0; m_x2 = 0;
                $display("flush: history cleared");
            end
            if ($urandom_range(0, 1) == 1) begin
                x0  = int'($urandom_range(0, 255));
                x1v = m_x1; x2v = m_x2;
                y   = A * x2v + B * x1v + C * x0 + int'($urandom_range(0, 2));
                if (y > 4095) y = 4095;
            end else begin
                y = int'($urandom_range(0, 4095));
            end
            send(y, int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
